// File: rtl/apb_i2c_master_arb_if.sv
// rtl/apb_i2c_master_arb_if.sv - requester, response and APB bus bundle for apb_i2c_master_arb
interface apb_i2c_master_arb_if #(
    parameter int ADDR_W = 4
);
    logic              req0_valid;
    logic              req0_ready;
    logic              req0_write;
    logic [ADDR_W-1:0] req0_addr;
    logic [31:0]       req0_wdata;

    logic              req1_valid;
    logic              req1_ready;
    logic              req1_write;
    logic [ADDR_W-1:0] req1_addr;
    logic [31:0]       req1_wdata;

    logic              rsp_valid;
    logic              rsp_id;
    logic [31:0]       rsp_rdata;
    logic [1:0]        rsp_code;
    logic              busy;

    logic              PSELx;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PADDR;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;

    // master: the arbiter/APB master view; slave: requesters plus bridge
    modport master (
        input  req0_valid, req0_write, req0_addr, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_wdata,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_rdata, rsp_code, busy,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PRDATA, PREADY, PSLVERR
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_code, busy,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PRDATA, PREADY, PSLVERR
    );
endinterface

// File: rtl/apb_i2c_master_arb.sv
// rtl/apb_i2c_master_arb.sv - two-requester round-robin APB master for the APB-I2C bridge
module apb_i2c_master_arb #(
    parameter int ADDR_W   = 4,
    parameter int WAIT_MAX = 16
) (
    input logic                  PCLK,
    input logic                  PRESETn,
    apb_i2c_master_arb_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_RESP
    } state_t;

    localparam int CNT_W = $clog2(WAIT_MAX + 1);

    localparam logic [1:0] CODE_OK     = 2'b00;
    localparam logic [1:0] CODE_SLVERR = 2'b01;
    localparam logic [1:0] CODE_TMO    = 2'b10;
    localparam logic [1:0] CODE_DECERR = 2'b11;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_wait;
    logic              r_last;
    logic              r_id;
    logic [31:0]       r_rdata;
    logic [1:0]        r_code;
    logic              r_psel;
    logic              r_penable;
    logic              r_pwrite;
    logic [31:0]       r_paddr;
    logic [31:0]       r_pwdata;

    logic              w_any;
    logic              w_gid;
    logic              w_grant;
    logic              w_gwrite;
    logic [ADDR_W-1:0] w_gaddr;
    logic [31:0]       w_gwdata;
    logic              w_legal;
    logic              w_timeout;
    logic              w_rsp;

    // On a tie the requester that did not win last time is served
    assign w_any    = bus.req0_valid | bus.req1_valid;
    assign w_gid    = (bus.req0_valid & bus.req1_valid) ? ~r_last : bus.req1_valid;
    assign w_grant  = (r_state == S_IDLE) & w_any;
    assign w_gwrite = w_gid ? bus.req1_write : bus.req0_write;
    assign w_gaddr  = w_gid ? bus.req1_addr  : bus.req0_addr;
    assign w_gwdata = w_gid ? bus.req1_wdata : bus.req0_wdata;

    assign w_legal = w_gwrite ? ((w_gaddr == ADDR_W'(4'h0)) ||
                                 (w_gaddr == ADDR_W'(4'h8)) ||
                                 (w_gaddr == ADDR_W'(4'hC)))
                              :  (w_gaddr == ADDR_W'(4'h4));

    // Last tolerated wait cycle: PREADY still low after WAIT_MAX ACCESS cycles
    assign w_timeout = (r_wait == CNT_W'(WAIT_MAX - 1)) & ~bus.PREADY;

    assign bus.req0_ready = w_grant & ~w_gid & bus.req0_valid;
    assign bus.req1_ready = w_grant &  w_gid & bus.req1_valid;

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_next = w_legal ? S_SETUP : S_RESP;
                end
            end
            S_SETUP: begin
                w_next = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.PREADY || w_timeout) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            r_wait    <= '0;
            r_last    <= 1'b1;
            r_id      <= 1'b0;
            r_rdata   <= '0;
            r_code    <= CODE_OK;
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_paddr   <= '0;
            r_pwdata  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_grant) begin
                        r_last  <= w_gid;
                        r_id    <= w_gid;
                        r_rdata <= '0;
                        if (w_legal) begin
                            r_code    <= CODE_OK;
                            r_psel    <= 1'b1;
                            r_penable <= 1'b0;
                            r_pwrite  <= w_gwrite;
                            r_paddr   <= 32'(w_gaddr);
                            r_pwdata  <= w_gwdata;
                        end else begin
                            r_code <= CODE_DECERR;
                        end
                    end
                end
                S_SETUP: begin
                    r_penable <= 1'b1;
                end
                S_ACCESS: begin
                    if (bus.PREADY) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_code    <= bus.PSLVERR ? CODE_SLVERR : CODE_OK;
                        r_rdata   <= (!r_pwrite && !bus.PSLVERR) ? bus.PRDATA : 32'h0;
                    end else if (w_timeout) begin
                        r_psel    <= 1'b0;
                        r_penable <= 1'b0;
                        r_code    <= CODE_TMO;
                    end else begin
                        r_wait <= r_wait + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    r_wait <= '0;
                end
                default: begin
                    r_wait <= '0;
                end
            endcase
        end
    end

    assign w_rsp         = (r_state == S_RESP);
    assign bus.rsp_valid = w_rsp;
    assign bus.rsp_id    = w_rsp & r_id;
    assign bus.rsp_rdata = w_rsp ? r_rdata : 32'h0;
    assign bus.rsp_code  = w_rsp ? r_code  : 2'b00;
    assign bus.busy      = (r_state != S_IDLE);

    assign bus.PSELx   = r_psel;
    assign bus.PENABLE = r_penable;
    assign bus.PWRITE  = r_pwrite;
    assign bus.PADDR   = r_paddr;
    assign bus.PWDATA  = r_pwdata;
endmodule

// File: tb/tb_apb_i2c_master_arb.sv
// tb/tb_apb_i2c_master_arb.sv - directed self-checking bench for apb_i2c_master_arb
module tb_apb_i2c_master_arb;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   wait_cfg = 0;
    int   acc_cnt = 0;

    apb_i2c_master_arb_if #(.ADDR_W(4)) bus ();

    apb_i2c_master_arb #(.ADDR_W(4), .WAIT_MAX(16)) dut (
        .PCLK    (clk),
        .PRESETn (rst_n),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Bridge model: PREADY rises after wait_cfg low ACCESS cycles; wait_cfg<0 never answers
    always @(posedge clk) acc_cnt <= (bus.PSELx && bus.PENABLE) ? acc_cnt + 1 : 0;
    assign bus.PREADY = bus.PSELx && bus.PENABLE && (wait_cfg >= 0) && (acc_cnt >= wait_cfg);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_cmd(input bit id, input bit wr, input logic [3:0] addr,
                           input logic [31:0] wd, output int lat, output logic [31:0] rd,
                           output logic [1:0] code, output logic rid, output logic psel_r);
        int k;
        @(negedge clk);
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_write = wr; bus.req1_addr = addr; bus.req1_wdata = wd;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_write = wr; bus.req0_addr = addr; bus.req0_wdata = wd;
        end
        #1;
        k = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready) && k < 20) begin
            @(negedge clk); #1; k++;
        end
        chk("accept", id ? bus.req1_ready : bus.req0_ready, 1);
        @(negedge clk);
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        lat = 1;
        #1;
        while (!bus.rsp_valid && lat < 40) begin
            @(negedge clk); #1; lat++;
        end
        chk("rsp_seen", bus.rsp_valid, 1);
        rd     = bus.rsp_rdata;
        code   = bus.rsp_code;
        rid    = bus.rsp_id;
        psel_r = bus.PSELx;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          lat;
        logic [31:0] rd;
        logic [1:0]  code;
        logic        rid;
        logic        psel_r;
        int          gcnt;
        int          k;
        logic        gseq [4];

        rst_n = 1'b0;
        bus.req0_valid = 0; bus.req0_write = 0; bus.req0_addr = 0; bus.req0_wdata = 0;
        bus.req1_valid = 0; bus.req1_write = 0; bus.req1_addr = 0; bus.req1_wdata = 0;
        bus.PRDATA = 0; bus.PSLVERR = 0;
        wait_cfg = 0;

        // T1: reset state then a single-cycle write to CONFIG
        repeat (2) @(negedge clk);
        chk("rst_psel", bus.PSELx, 0);
        chk("rst_penable", bus.PENABLE, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_paddr", bus.PADDR, 0);
        rst_n = 1'b1;

        @(negedge clk);
        bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 4'h8; bus.req0_wdata = 32'h0000_1A2B;
        #1;
        chk("t1_ready0", bus.req0_ready, 1);
        chk("t1_ready1", bus.req1_ready, 0);
        @(negedge clk);
        bus.req0_valid = 0;
        #1;
        chk("t1_setup_psel", bus.PSELx, 1);
        chk("t1_setup_penable", bus.PENABLE, 0);
        chk("t1_setup_paddr", bus.PADDR, 32'h8);
        chk("t1_setup_pwdata", bus.PWDATA, 32'h0000_1A2B);
        chk("t1_setup_pwrite", bus.PWRITE, 1);
        chk("t1_busy", bus.busy, 1);
        chk("t1_setup_rsp", bus.rsp_valid, 0);
        @(negedge clk); #1;
        chk("t1_access_psel", bus.PSELx, 1);
        chk("t1_access_penable", bus.PENABLE, 1);
        chk("t1_access_pwdata", bus.PWDATA, 32'h0000_1A2B);
        chk("t1_access_rsp", bus.rsp_valid, 0);
        @(negedge clk); #1;
        chk("t1_rsp_valid", bus.rsp_valid, 1);
        chk("t1_rsp_code", bus.rsp_code, 2'b00);
        chk("t1_rsp_id", bus.rsp_id, 0);
        chk("t1_rsp_rdata", bus.rsp_rdata, 0);
        chk("t1_resp_psel", bus.PSELx, 0);
        @(negedge clk); #1;
        chk("t1_rsp_drop", bus.rsp_valid, 0);
        chk("t1_idle_busy", bus.busy, 0);
        chk("t1_paddr_held", bus.PADDR, 32'h8);

        // T2: read RX FIFO with three wait states
        wait_cfg = 3;
        bus.PRDATA = 32'hDEAD_BEEF;
        run_cmd(1'b1, 1'b0, 4'h4, 32'h0, lat, rd, code, rid, psel_r);
        chk("t2_latency", lat, 6);
        chk("t2_rdata", rd, 32'hDEAD_BEEF);
        chk("t2_code", code, 2'b00);
        chk("t2_id", rid, 1);
        bus.PRDATA = 32'h0;
        wait_cfg = 0;

        // T4: illegal write 0x4 and read 0xC answer DECERR without touching APB
        run_cmd(1'b0, 1'b1, 4'h4, 32'h1234_5678, lat, rd, code, rid, psel_r);
        chk("t4a_latency", lat, 1);
        chk("t4a_code", code, 2'b11);
        chk("t4a_psel", psel_r, 0);
        chk("t4a_rdata", rd, 0);
        chk("t4a_paddr_kept", bus.PADDR, 32'h4);
        run_cmd(1'b0, 1'b0, 4'hC, 32'h0, lat, rd, code, rid, psel_r);
        chk("t4b_latency", lat, 1);
        chk("t4b_code", code, 2'b11);
        chk("t4b_psel", psel_r, 0);
        chk("t4b_id", rid, 0);

        // T5: bridge never answers -> timeout after 16 ACCESS cycles
        wait_cfg = -1;
        run_cmd(1'b1, 1'b1, 4'hC, 32'h0000_00FF, lat, rd, code, rid, psel_r);
        chk("t5_latency", lat, 18);
        chk("t5_code", code, 2'b10);
        chk("t5_psel", psel_r, 0);
        chk("t5_penable", bus.PENABLE, 0);
        @(negedge clk); #1;
        chk("t5_idle", bus.busy, 0);

        // T6a: slave error on TX FIFO write
        wait_cfg = 0;
        bus.PSLVERR = 1;
        run_cmd(1'b0, 1'b1, 4'h0, 32'h0000_00AA, lat, rd, code, rid, psel_r);
        chk("t6_latency", lat, 3);
        chk("t6_code", code, 2'b01);
        chk("t6_rdata", rd, 0);
        bus.PSLVERR = 0;

        // T3: both requesters continuously valid after a fresh reset
        do_reset();
        @(negedge clk);
        bus.req0_valid = 1; bus.req0_write = 1; bus.req0_addr = 4'h0; bus.req0_wdata = 32'h0000_0A0A;
        bus.req1_valid = 1; bus.req1_write = 1; bus.req1_addr = 4'hC; bus.req1_wdata = 32'h0000_0B0B;
        #1;
        gcnt = 0;
        k = 0;
        while (gcnt < 4 && k < 60) begin
            if (bus.req0_ready || bus.req1_ready) begin
                gseq[gcnt] = bus.req1_ready;
                gcnt++;
            end
            @(negedge clk); #1;
            k++;
        end
        bus.req0_valid = 0;
        bus.req1_valid = 0;
        chk("t3_grants", gcnt, 4);
        chk("t3_g0", gseq[0], 0);
        chk("t3_g1", gseq[1], 1);
        chk("t3_g2", gseq[2], 0);
        chk("t3_g3", gseq[3], 1);
        k = 0;
        while (!bus.rsp_valid && k < 10) begin
            @(negedge clk); #1; k++;
        end
        chk("t3_last_rsp_id", bus.rsp_id, 1);

        // T6b: reset during ACCESS drops the transfer immediately
        wait_cfg = -1;
        @(negedge clk);
        bus.req1_valid = 1; bus.req1_write = 1; bus.req1_addr = 4'h8; bus.req1_wdata = 32'h0000_5555;
        @(negedge clk);
        bus.req1_valid = 0;
        @(negedge clk); #1;
        chk("t6b_in_access", bus.PENABLE, 1);
        rst_n = 1'b0;
        #1;
        chk("t6b_psel", bus.PSELx, 0);
        chk("t6b_penable", bus.PENABLE, 0);
        chk("t6b_busy", bus.busy, 0);
        chk("t6b_paddr", bus.PADDR, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("t6b_no_rsp", bus.rsp_valid, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk); #1;
            chk("t6b_no_rsp_after", bus.rsp_valid, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
